stopwatch_ctrl: RTL and testbench

Run/pause/lap/reset controller that sequences the seconds counter in the stopwatch datapath. It divides the system clock into a one-cycle-per-second count enable and issues the counter's synchronous clear. It tracks minutes from the seconds-counter rollover and provides a lap-hold flag that freezes the display while counting continues.

---
 rtl/stopwatch_ctrl_if.sv | 26 ++
 rtl/stopwatch_ctrl.sv | 122 ++++++++++++
 tb/tb_stopwatch_ctrl.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/stopwatch_ctrl_if.sv
// Button/counter handshake bundle between the stopwatch front panel
// logic and the run/pause/lap controller.
interface stopwatch_ctrl_if;
    logic       btn_start;
    logic       btn_lap;
    logic       btn_reset;
    logic       sec_overflow;
    logic       sec_en;
    logic       sec_clr;
    logic [5:0] minutes;
    logic       hour_wrap;
    logic       running;
    logic       lap_hold;

    // Front panel / datapath side: drives buttons and rollover, observes controls.
    modport master (
        output btn_start, btn_lap, btn_reset, sec_overflow,
        input  sec_en, sec_clr, minutes, hour_wrap, running, lap_hold
    );

    // Controller side.
    modport slave (
        input  btn_start, btn_lap, btn_reset, sec_overflow,
        output sec_en, sec_clr, minutes, hour_wrap, running, lap_hold
    );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch run/pause/lap/reset controller: divides clk into a one-pulse-
// per-second enable for the seconds counter, clears that counter on a
// return-to-zero, and counts minutes from the seconds rollover.
module stopwatch_ctrl #(
    parameter int TICKS_PER_SEC = 50000000
) (
    input  logic            clk,
    input  logic            rst,
    stopwatch_ctrl_if.slave bus
);

    localparam int            PW   = $clog2(TICKS_PER_SEC);
    localparam logic [PW-1:0] TERM = PW'(TICKS_PER_SEC - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        LAP,
        PAUSED
    } state_t;

    state_t        state;
    state_t        next_state;
    logic [PW-1:0] prescaler;
    logic [5:0]    minutes_q;
    logic          sec_en_q;
    logic          sec_clr_q;
    logic          hour_wrap_q;
    logic          running_q;
    logic          lap_hold_q;

    logic          clear_accept;
    logic          at_terminal;
    logic          minute_step;

    // Return-to-zero is only honoured while paused; elsewhere btn_reset is ignored.
    assign clear_accept = (state == PAUSED) && bus.btn_reset;
    assign at_terminal  = (prescaler == TERM);
    assign minute_step  = sec_en_q && bus.sec_overflow;

    // Button decode with btn_reset > btn_start > btn_lap precedence.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (bus.btn_start)
                    next_state = RUN;
            end
            RUN: begin
                if (bus.btn_start)
                    next_state = PAUSED;
                else if (bus.btn_lap)
                    next_state = LAP;
            end
            LAP: begin
                if (bus.btn_start)
                    next_state = PAUSED;
                else if (bus.btn_lap)
                    next_state = RUN;
            end
            PAUSED: begin
                if (bus.btn_reset)
                    next_state = IDLE;
                else if (bus.btn_start)
                    next_state = RUN;
            end
            default: next_state = IDLE;
        endcase
    end

    // State, prescaler, minutes and all registered outputs advance together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            prescaler   <= '0;
            minutes_q   <= '0;
            sec_en_q    <= 1'b0;
            sec_clr_q   <= 1'b0;
            hour_wrap_q <= 1'b0;
            running_q   <= 1'b0;
            lap_hold_q  <= 1'b0;
        end else begin
            state      <= next_state;
            running_q  <= (next_state == RUN) || (next_state == LAP);
            lap_hold_q <= (next_state == LAP);
            sec_clr_q  <= clear_accept;

            // A terminal count reached on the pausing edge still owes its
            // pulse, so PAUSED issues it and parks the prescaler at 0.
            sec_en_q <= (state != IDLE) && at_terminal && !clear_accept;

            case (state)
                RUN, LAP: prescaler <= at_terminal ? '0 : prescaler + PW'(1);
                PAUSED: begin
                    if (clear_accept || at_terminal)
                        prescaler <= '0;
                end
                default: prescaler <= '0;
            endcase

            hour_wrap_q <= 1'b0;
            if (clear_accept) begin
                minutes_q <= '0;
            end else if (minute_step) begin
                if (minutes_q == 6'd59) begin
                    minutes_q   <= '0;
                    hour_wrap_q <= 1'b1;
                end else begin
                    minutes_q <= minutes_q + 6'd1;
                end
            end
        end
    end

    assign bus.sec_en    = sec_en_q;
    assign bus.sec_clr   = sec_clr_q;
    assign bus.minutes   = minutes_q;
    assign bus.hour_wrap = hour_wrap_q;
    assign bus.running   = running_q;
    assign bus.lap_hold  = lap_hold_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl with a 4-tick second: a cycle
// model of the stopwatch rules is compared every cycle, and directed
// scenarios pin hand-computed values.
module tb_stopwatch_ctrl;

    localparam int TICKS = 4;

    logic clk = 1'b0;
    logic rst;
    logic btn_start;
    logic btn_lap;
    logic btn_reset;
    logic sec_overflow;

    int cmp_count = 0;
    int err_count = 0;

    // Model: whether time is advancing, lap display frozen, paused, plus
    // elapsed ticks in the current second and the minute count.
    bit m_counting = 1'b0;
    bit m_lap_on   = 1'b0;
    bit m_paused   = 1'b0;
    int m_ticks    = 0;
    int m_minutes  = 0;
    bit exp_sec_en    = 1'b0;
    bit exp_sec_clr   = 1'b0;
    bit exp_hour_wrap = 1'b0;

    stopwatch_ctrl_if bus ();

    assign bus.btn_start    = btn_start;
    assign bus.btn_lap      = btn_lap;
    assign bus.btn_reset    = btn_reset;
    assign bus.sec_overflow = sec_overflow;

    stopwatch_ctrl #(.TICKS_PER_SEC(TICKS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        cmp_count++;
        if (actual != expected) begin
            err_count++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic l, input logic r);
        btn_start = s;
        btn_lap   = l;
        btn_reset = r;
        @(negedge clk);
        btn_start = 1'b0;
        btn_lap   = 1'b0;
        btn_reset = 1'b0;
    endtask

    // Stopwatch rules evaluated once per clock from the pre-edge situation.
    always @(posedge clk or posedge rst) begin
        bit was_idle;
        bit clear_now;
        bit step_minute;
        if (rst) begin
            m_counting    = 1'b0;
            m_lap_on      = 1'b0;
            m_paused      = 1'b0;
            m_ticks       = 0;
            m_minutes     = 0;
            exp_sec_en    = 1'b0;
            exp_sec_clr   = 1'b0;
            exp_hour_wrap = 1'b0;
        end else begin
            was_idle    = !m_counting && !m_paused;
            clear_now   = m_paused && btn_reset;
            step_minute = exp_sec_en && sec_overflow;

            exp_sec_en    = !was_idle && (m_ticks == TICKS - 1) && !clear_now;
            exp_sec_clr   = clear_now;
            exp_hour_wrap = !clear_now && step_minute && (m_minutes == 59);

            if (clear_now)
                m_minutes = 0;
            else if (step_minute)
                m_minutes = (m_minutes + 1) % 60;

            if (clear_now || was_idle)
                m_ticks = 0;
            else if (m_counting)
                m_ticks = (m_ticks + 1) % TICKS;
            else if (m_ticks == TICKS - 1)
                m_ticks = 0;

            if (clear_now) begin
                m_counting = 1'b0;
                m_lap_on   = 1'b0;
                m_paused   = 1'b0;
            end else if (btn_start) begin
                if (m_counting) begin
                    m_counting = 1'b0;
                    m_lap_on   = 1'b0;
                    m_paused   = 1'b1;
                end else begin
                    m_counting = 1'b1;
                    m_paused   = 1'b0;
                end
            end else if (btn_lap && m_counting) begin
                m_lap_on = !m_lap_on;
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (!rst) begin
            checkOutput("mdl_sec_en", int'(bus.sec_en), int'(exp_sec_en));
            checkOutput("mdl_sec_clr", int'(bus.sec_clr), int'(exp_sec_clr));
            checkOutput("mdl_minutes", int'(bus.minutes), m_minutes);
            checkOutput("mdl_hour_wrap", int'(bus.hour_wrap), int'(exp_hour_wrap));
            checkOutput("mdl_running", int'(bus.running), int'(m_counting));
            checkOutput("mdl_lap_hold", int'(bus.lap_hold), int'(m_lap_on));
        end
    end

    // Runaway guard.
    initial begin
        #50000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios with hand-computed expectations.
    initial begin
        int hw_count;
        rst          = 1'b1;
        btn_start    = 1'b0;
        btn_lap      = 1'b0;
        btn_reset    = 1'b0;
        sec_overflow = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_running", int'(bus.running), 0);
        checkOutput("rst_sec_en", int'(bus.sec_en), 0);
        checkOutput("rst_minutes", int'(bus.minutes), 0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("idle_lap_hold", int'(bus.lap_hold), 0);
        checkOutput("idle_sec_clr", int'(bus.sec_clr), 0);

        $display("[TB] start from idle, seconds cadence");
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("start_running", int'(bus.running), 1);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            checkOutput($sformatf("cadence_k%0d", k), int'(bus.sec_en), (k % 4 == 0) ? 1 : 0);
        end

        $display("[TB] pause then return to zero");
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("pause_running", int'(bus.running), 0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("clr_pulse", int'(bus.sec_clr), 1);
        checkOutput("clr_running", int'(bus.running), 0);
        checkOutput("clr_minutes", int'(bus.minutes), 0);
        @(negedge clk);
        checkOutput("clr_single", int'(bus.sec_clr), 0);

        $display("[TB] pause mid-second and resume");
        applyStimulus(1'b1, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("midpause_running", int'(bus.running), 0);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            checkOutput("paused_no_sec_en", int'(bus.sec_en), 0);
        end
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("resume_r1", int'(bus.sec_en), 0);
        @(negedge clk);
        checkOutput("resume_r2", int'(bus.sec_en), 0);
        @(negedge clk);
        checkOutput("resume_sec_en", int'(bus.sec_en), 1);

        $display("[TB] reset ignored in run, lap toggling");
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("run_reset_no_clr", int'(bus.sec_clr), 0);
        checkOutput("run_reset_running", int'(bus.running), 1);
        repeat (2) @(negedge clk);
        checkOutput("run_reset_gap", int'(bus.sec_en), 0);
        @(negedge clk);
        checkOutput("run_reset_cadence", int'(bus.sec_en), 1);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("lap_on", int'(bus.lap_hold), 1);
        checkOutput("lap_running", int'(bus.running), 1);
        repeat (2) @(negedge clk);
        @(negedge clk);
        checkOutput("lap_sec_en", int'(bus.sec_en), 1);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("lap_off", int'(bus.lap_hold), 0);
        checkOutput("lap_off_running", int'(bus.running), 1);

        $display("[TB] start+lap together in run");
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("both_running", int'(bus.running), 0);
        checkOutput("both_lap_hold", int'(bus.lap_hold), 0);

        $display("[TB] minute counting through the hour wrap");
        applyStimulus(1'b0, 1'b0, 1'b1);
        sec_overflow = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("min_start", int'(bus.minutes), 0);
        hw_count = 0;
        for (int k = 1; k <= 250; k++) begin
            @(negedge clk);
            if (bus.hour_wrap)
                hw_count++;
            if (k == 237)
                checkOutput("min_59", int'(bus.minutes), 59);
            if (k == 241) begin
                checkOutput("hour_wrap_pulse", int'(bus.hour_wrap), 1);
                checkOutput("min_wrapped", int'(bus.minutes), 0);
            end
        end
        checkOutput("hour_wrap_count", hw_count, 1);
        checkOutput("min_after_wrap", int'(bus.minutes), 2);

        $display("[TB] pause on terminal count");
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("tc_pause_running", int'(bus.running), 0);
        @(negedge clk);
        checkOutput("tc_pending_sec_en", int'(bus.sec_en), 1);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            checkOutput("tc_paused_quiet", int'(bus.sec_en), 0);
        end
        checkOutput("tc_minutes", int'(bus.minutes), 3);
        applyStimulus(1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            checkOutput($sformatf("tc_resume_k%0d", k), int'(bus.sec_en), (k == 4) ? 1 : 0);
        end

        $display("[TB] asynchronous reset mid-count");
        repeat (3) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("arst_sec_en", int'(bus.sec_en), 0);
        checkOutput("arst_sec_clr", int'(bus.sec_clr), 0);
        checkOutput("arst_minutes", int'(bus.minutes), 0);
        checkOutput("arst_hour_wrap", int'(bus.hour_wrap), 0);
        checkOutput("arst_running", int'(bus.running), 0);
        checkOutput("arst_lap_hold", int'(bus.lap_hold), 0);
        @(negedge clk);
        rst          = 1'b0;
        sec_overflow = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checkOutput("post_rst_sec_en", int'(bus.sec_en), 0);
            checkOutput("post_rst_running", int'(bus.running), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
        $finish;
    end

endmodule
